regfile_2r1w_fill: RTL and testbench

Parametrised register file with two independent asynchronous read ports and one synchronous write port. It succeeds the single-port 8x4 switch-driven register file. A built-in fill sequencer writes a constant to every entry, one entry per clock, with BUSY/DONE status. It sits under board-level top modules that drive addresses and data from switches and show read values on seven-segment displays.

---
 rtl/regfile_2r1w_fill.sv | 113 +++++++++++
 tb/tb_regfile_2r1w_fill.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_fill.sv
// Two-read/one-write register file with a built-in fill sequencer (BUSY/DONE status).
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_2r1w_fill #(
  parameter int NUM_REGS  = 8,
  parameter int REG_SIZE  = 4,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 WrEn,
  input  logic [ADDR_SIZE-1:0] WA,
  input  logic [REG_SIZE-1:0]  DIN,
  input  logic [ADDR_SIZE-1:0] RA0,
  input  logic [ADDR_SIZE-1:0] RA1,
  output logic [REG_SIZE-1:0]  DOUT0,
  output logic [REG_SIZE-1:0]  DOUT1,
  input  logic                 FILL,
  input  logic [REG_SIZE-1:0]  FILL_VAL,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [1:0] {IDLE, FILLING, DONE_ST} state_e;

  localparam logic [ADDR_SIZE:0]   NREGS = (ADDR_SIZE+1)'(NUM_REGS);
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(NUM_REGS-1);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [REG_SIZE-1:0]  fill_q, fill_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [REG_SIZE-1:0]  regs_q [NUM_REGS];
  logic                 wr_ok;
  logic [REG_SIZE-1:0]  dout0, dout1;

  assign wr_ok = WrEn && (state_q == IDLE) && ({1'b0, WA} < NREGS);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counter holds at LAST on exit; a new fill reloads it to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (FILL) begin
        fill_d  = FILL_VAL;
        cnt_d   = '0;
        state_d = FILLING;
      end
      FILLING: begin
        if (cnt_q == LAST) state_d = DONE_ST;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == FILLING);
    done_d = (state_d == DONE_ST);
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (state_q == FILLING && cnt_q == ADDR_SIZE'(i)) regs_q[i] <= fill_q;
        else if (wr_ok && WA == ADDR_SIZE'(i))            regs_q[i] <= DIN;
      end
    end
  end

  // Address decode by compare keeps out-of-range reads at zero.
  always_comb begin
    dout0 = '0;
    dout1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RA0 == ADDR_SIZE'(i)) dout0 = regs_q[i];
      if (RA1 == ADDR_SIZE'(i)) dout1 = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && RA0 == WA) dout0 = DIN;
    if (wr_ok && RA1 == WA) dout1 = DIN;
    if (state_q == FILLING && RA0 == cnt_q) dout0 = fill_q;
    if (state_q == FILLING && RA1 == cnt_q) dout1 = fill_q;
`else
`endif
  end

  assign DOUT0 = dout0;
  assign DOUT1 = dout1;

endmodule

// File: tb/tb_regfile_2r1w_fill.sv
// Directed bench for regfile_2r1w_fill: 8-entry instance plus a 6-entry instance.
module tb_regfile_2r1w_fill;

  logic       CLK = 1'b0;
  logic       CLR, WrEn, FILL, BUSY, DONE;
  logic [2:0] WA, RA0, RA1;
  logic [3:0] DIN, FILL_VAL, DOUT0, DOUT1;

  logic       e_we, e_fill, e_busy, e_done;
  logic [2:0] e_wa, e_ra0, e_ra1;
  logic [3:0] e_din, e_fv, e_d0, e_d1;

  int n_cmp = 0;
  int n_bad = 0;
  int nb, nd, dat;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [3:0] din;
    logic [2:0] ra0, ra1;
    logic [3:0] e0, e1;
  } vec_t;
  vec_t tbl[7];

  always #5 CLK = ~CLK;

  regfile_2r1w_fill dut (
    .CLK(CLK), .CLR(CLR), .WrEn(WrEn), .WA(WA), .DIN(DIN), .RA0(RA0), .RA1(RA1),
    .DOUT0(DOUT0), .DOUT1(DOUT1), .FILL(FILL), .FILL_VAL(FILL_VAL), .BUSY(BUSY), .DONE(DONE)
  );

  regfile_2r1w_fill #(.NUM_REGS(6)) u6 (
    .CLK(CLK), .CLR(CLR), .WrEn(e_we), .WA(e_wa), .DIN(e_din), .RA0(e_ra0), .RA1(e_ra1),
    .DOUT0(e_d0), .DOUT1(e_d1), .FILL(e_fill), .FILL_VAL(e_fv), .BUSY(e_busy), .DONE(e_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic read_all(input string nm, input logic [3:0] exp);
    for (int i = 0; i < 8; i++) begin
      RA0 = 3'(i); RA1 = 3'(7 - i); #1;
      chk($sformatf("%s.ra0=%0d", nm, i), DOUT0, exp);
      chk($sformatf("%s.ra1=%0d", nm, 7 - i), DOUT1, exp);
    end
  endtask

  // Launch a fill and observe BUSY/DONE for 14 cycles after the FILL edge.
  task automatic fill_watch(input logic [3:0] v, input bit inj,
                            output int o_nb, output int o_nd, output int o_dat);
    FILL_VAL = v; FILL = 1'b1;
    tick();
    FILL = 1'b0; FILL_VAL = 4'h3;
    o_nb = 0; o_nd = 0; o_dat = -1;
    for (int t = 0; t < 14; t++) begin
      if (BUSY) o_nb++;
      if (DONE) begin o_nd++; o_dat = t; end
      if (inj && t == 3) begin
        WrEn = 1'b1; WA = 3'd2; DIN = 4'h1; RA0 = 3'd1; RA1 = 3'd4; #1;
        chk("partial.ra0=1", DOUT0, v);
        chk("partial.ra1=4", DOUT1, 4'h0);
      end
      if (inj && t == 4) WrEn = 1'b0;
      tick();
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'd3, 4'hA, 3'd3, 3'd6, 4'hA, 4'h0};
    tbl[1] = '{1'b1, 3'd6, 4'h5, 3'd3, 3'd6, 4'hA, 4'h5};
    tbl[2] = '{1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 4'hA, 4'hA};
    tbl[3] = '{1'b1, 3'd0, 4'h7, 3'd0, 3'd1, 4'h7, 4'h0};
    tbl[4] = '{1'b1, 3'd7, 4'hF, 3'd7, 3'd0, 4'hF, 4'h7};
    tbl[5] = '{1'b0, 3'd7, 4'h2, 3'd7, 3'd6, 4'hF, 4'h5};
    tbl[6] = '{1'b1, 3'd3, 4'h1, 3'd3, 3'd7, 4'h1, 4'hF};

    CLR = 1'b1; WrEn = 0; FILL = 0; WA = 0; RA0 = 0; RA1 = 0; DIN = 0; FILL_VAL = 0;
    e_we = 0; e_fill = 0; e_wa = 0; e_ra0 = 0; e_ra1 = 0; e_din = 0; e_fv = 0;
    #12 CLR = 1'b0;
    tick();
    chk("rst.busy", BUSY, 1'b0);
    chk("rst.done", DONE, 1'b0);

    // Preload random data, then clear asynchronously between edges
    for (int i = 0; i < 8; i++) begin
      WrEn = 1'b1; WA = 3'(i); DIN = 4'($urandom_range(1, 15));
      tick();
    end
    WrEn = 1'b0;
    #3 CLR = 1'b1; #1;
    read_all("clr", 4'h0);
    chk("clr.busy", BUSY, 1'b0);
    chk("clr.done", DONE, 1'b0);
    CLR = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      WrEn = tbl[i].we; WA = tbl[i].wa; DIN = tbl[i].din;
      RA0 = tbl[i].ra0; RA1 = tbl[i].ra1;
      tick();
      chk($sformatf("vec%0d.d0", i), DOUT0, tbl[i].e0);
      chk($sformatf("vec%0d.d1", i), DOUT1, tbl[i].e1);
    end
    WrEn = 1'b0;

    // Same-cycle write visibility on entry 2 (currently 0)
    WrEn = 1'b1; WA = 3'd2; DIN = 4'h9; RA0 = 3'd2; RA1 = 3'd3; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp.pre.d0", DOUT0, 4'h9);
`else
    chk("byp.pre.d0", DOUT0, 4'h0);
`endif
    chk("byp.pre.d1", DOUT1, 4'h1);
    tick();
    WrEn = 1'b0;
    chk("byp.post.d0", DOUT0, 4'h9);

    // Full fill with a lost mid-fill write
    fill_watch(4'hC, 1'b1, nb, nd, dat);
    chk("fill.busy_cycles", 32'(nb), 32'd8);
    chk("fill.done_pulses", 32'(nd), 32'd1);
    chk("fill.done_cycle", 32'(dat), 32'd8);
    read_all("fillC", 4'hC);

    // Reset after three fill writes
    FILL_VAL = 4'h6; FILL = 1'b1;
    tick();
    FILL = 1'b0;
    repeat (3) tick();
    RA0 = 3'd2; #1;
    chk("mid.ra0=2", DOUT0, 4'h6);
    CLR = 1'b1; #1;
    chk("mid.busy", BUSY, 1'b0);
    read_all("mid", 4'h0);
    CLR = 1'b0;
    tick();
    nb = 0; nd = 0;
    for (int t = 0; t < 12; t++) begin
      if (BUSY) nb++;
      if (DONE) nd++;
      tick();
    end
    chk("mid.busy_after", 32'(nb), 32'd0);
    chk("mid.done_after", 32'(nd), 32'd0);
    fill_watch(4'h5, 1'b0, nb, nd, dat);
    chk("refill.busy_cycles", 32'(nb), 32'd8);
    chk("refill.done_cycle", 32'(dat), 32'd8);
    read_all("fill5", 4'h5);

    // Six-entry instance: out-of-range drops, shorter fill
    e_we = 1'b1; e_wa = 3'd7; e_din = 4'hF;
    tick();
    e_wa = 3'd5; e_din = 4'h3;
    tick();
    e_we = 1'b0; e_ra0 = 3'd7; e_ra1 = 3'd5; #1;
    chk("n6.ra0=7", e_d0, 4'h0);
    chk("n6.ra1=5", e_d1, 4'h3);
    e_ra0 = 3'd6; #1;
    chk("n6.ra0=6", e_d0, 4'h0);
    e_fv = 4'hA; e_fill = 1'b1;
    tick();
    e_fill = 1'b0;
    nb = 0; nd = 0; dat = -1;
    for (int t = 0; t < 12; t++) begin
      if (e_busy) nb++;
      if (e_done) begin nd++; dat = t; end
      tick();
    end
    chk("n6.busy_cycles", 32'(nb), 32'd6);
    chk("n6.done_cycle", 32'(dat), 32'd6);
    e_ra0 = 3'd7; e_ra1 = 3'd5; #1;
    chk("n6.fill.ra0=7", e_d0, 4'h0);
    chk("n6.fill.ra1=5", e_d1, 4'hA);
    e_ra1 = 3'd0; #1;
    chk("n6.fill.ra1=0", e_d1, 4'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
